// File: rtl/quad_step_decoder.sv
// Quadrature front-end: synchronise and debounce A/B, then decode each
// legal Gray-code move into a step pulse plus direction, flagging double edges.
module quad_step_decoder #(
   parameter int FILT_LEN = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   output logic             step,
   output logic             up,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [1:0]       phase,
   output logic             valid
);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   localparam logic [7:0] LIM    = 8'(FILT_LEN - 1);
   localparam logic [7:0] STABLE = 8'(FILT_LEN);

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      s1;
   logic [1:0]      s2;
   logic [1:0]      last_s2;
   logic [7:0]      stab;
   logic [1:0][7:0] fcnt;
   logic [1:0]      filt;
   logic [1:0]      prev;
   logic [1:0]      fwd;
   logic [1:0]      mv;
   logic            stable;
   logic            go_run;
   logic            in_run;

   // Bit 1 carries channel A, bit 0 channel B throughout.
   assign in_run = (state == RUN);
   assign stable = (s2 == last_s2);
   assign go_run = (state == INIT) && stable && ((stab + 8'd1) == STABLE);

   always_ff @(posedge clk) begin
      if (rst) state <= INIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         INIT: if (go_run) state_nxt = RUN;
         RUN:  state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 2'b00;
         s2 <= 2'b00;
      end else begin
         s1 <= {a_in, b_in};
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || in_run) begin
         stab    <= 8'd0;
         last_s2 <= 2'b00;
      end else begin
         last_s2 <= s2;
         stab    <= stable ? stab + 8'd1 : 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt <= 2'b00;
         fcnt <= '0;
      end else if (go_run) begin
         filt <= s2;
         fcnt <= '0;
      end else if (in_run) begin
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == filt[i]) begin
               fcnt[i] <= 8'd0;
            end else if (fcnt[i] == LIM) begin
               filt[i] <= s2[i];
               fcnt[i] <= 8'd0;
            end else begin
               fcnt[i] <= fcnt[i] + 8'd1;
            end
         end
      end else begin
         fcnt <= '0;
      end
   end

   // Forward successor of prev: 00->10->11->01->00.
   always_comb begin
      fwd = 2'b00;
      unique case (prev)
         2'b00: fwd = 2'b10;
         2'b10: fwd = 2'b11;
         2'b11: fwd = 2'b01;
         2'b01: fwd = 2'b00;
      endcase
   end

   assign mv = prev ^ filt;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev    <= 2'b00;
         step    <= 1'b0;
         err     <= 1'b0;
         up      <= 1'b0;
         err_cnt <= '0;
      end else begin
         step <= 1'b0;
         err  <= 1'b0;
         if (go_run) begin
            prev <= s2;
         end else if (in_run) begin
            prev <= filt;
            if (mv == 2'b11) begin
               err <= 1'b1;
               if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end else if (mv != 2'b00) begin
               step <= 1'b1;
               up   <= (filt == fwd);
            end
         end
      end
   end

   assign phase = filt;
   assign valid = in_run;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: a vector table of held input levels
// plus hand sequences for reset, latency, glitches and mid-run reset.
module tb_quad_step_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_in = 1'b0;
   logic       b_in = 1'b0;
   logic       step;
   logic       up;
   logic       err;
   logic [1:0] err_cnt;
   logic [1:0] phase;
   logic       valid;

   int checks = 0;
   int errors = 0;
   int nstep  = 0;
   int nerr   = 0;
   int up_log [8];

   typedef struct {
      logic       a;
      logic       b;
      logic [1:0] ph;
      logic       upv;
      int         steps;
      int         errs;
      logic [1:0] ecnt;
   } vec_t;

   vec_t tv [13];

   quad_step_decoder #(.FILT_LEN(4), .ERR_W(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .a_in    (a_in),
      .b_in    (b_in),
      .step    (step),
      .up      (up),
      .err     (err),
      .err_cnt (err_cnt),
      .phase   (phase),
      .valid   (valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clr();
      nstep = 0;
      nerr  = 0;
      for (int i = 0; i < 8; i++) up_log[i] = -1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (step) begin
            if (nstep < 8) up_log[nstep] = int'(up);
            nstep++;
         end
         if (err) nerr++;
         if (step || err) chk("step_err_excl", int'(step && err), 0);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_step"}, int'(step), 0);
      chk({tag, "_up"}, int'(up), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_errcnt"}, int'(err_cnt), 0);
      chk({tag, "_phase"}, int'(phase), 0);
      chk({tag, "_valid"}, int'(valid), 0);
   endtask

   initial begin
      int vk;
      int lat;

      //          a     b     ph     up  st er cnt
      tv[0]  = '{1'b1, 1'b0, 2'b10, 1'b1, 1, 0, 2'd0};
      tv[1]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1, 0, 2'd0};
      tv[2]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1, 0, 2'd0};
      tv[3]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1, 0, 2'd0};
      tv[4]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1, 0, 2'd0};
      tv[5]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1, 0, 2'd0};
      tv[6]  = '{1'b1, 1'b0, 2'b10, 1'b0, 1, 0, 2'd0};
      tv[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1, 0, 2'd0};
      tv[8]  = '{1'b1, 1'b1, 2'b11, 1'b0, 0, 1, 2'd1};
      tv[9]  = '{1'b0, 1'b0, 2'b00, 1'b0, 0, 1, 2'd2};
      tv[10] = '{1'b1, 1'b1, 2'b11, 1'b0, 0, 1, 2'd3};
      tv[11] = '{1'b0, 1'b0, 2'b00, 1'b0, 0, 1, 2'd3};
      tv[12] = '{1'b1, 1'b1, 2'b11, 1'b0, 0, 1, 2'd3};

      // Reset state, then release with both inputs high.
      a_in = 1'b1;
      b_in = 1'b1;
      clr();
      run(3);
      chk_reset_vals("rst");
      rst = 1'b0;
      clr();
      vk = 0;
      for (int k = 1; k <= 20; k++) begin
         run(1);
         if (valid && vk == 0) vk = k;
      end
      chk("init11_valid_late", int'(vk >= 6), 1);
      chk("init11_valid_early", int'(vk <= 8), 1);
      chk("init11_phase", int'(phase), 3);
      chk("init11_steps", nstep, 0);
      chk("init11_errs", nerr, 0);
      chk("init11_errcnt", int'(err_cnt), 0);

      // Restart at phase 00.
      rst = 1'b1;
      a_in = 1'b0;
      b_in = 1'b0;
      run(2);
      rst = 1'b0;
      run(12);
      chk("init00_valid", int'(valid), 1);
      chk("init00_phase", int'(phase), 0);

      // Latency: step seen after the 7th edge from the input change.
      clr();
      a_in = 1'b1;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         run(1);
         if (step && lat == 0) lat = k;
      end
      chk("lat_edges", lat, 7);
      chk("lat_steps", nstep, 1);
      chk("lat_up", up_log[0], 1);
      a_in = 1'b0;
      run(12);

      // Forward, reverse, illegal and recovery vectors.
      for (int i = 0; i < 13; i++) begin
         clr();
         a_in = tv[i].a;
         b_in = tv[i].b;
         run(10);
         chk($sformatf("v%0d_phase", i), int'(phase), int'(tv[i].ph));
         chk($sformatf("v%0d_up", i), int'(up), int'(tv[i].upv));
         chk($sformatf("v%0d_steps", i), nstep, tv[i].steps);
         chk($sformatf("v%0d_errs", i), nerr, tv[i].errs);
         chk($sformatf("v%0d_errcnt", i), int'(err_cnt), int'(tv[i].ecnt));
      end

      // Back to 00 legally: 11->01->00 are forward moves.
      clr();
      b_in = 1'b1;
      a_in = 1'b0;
      run(10);
      a_in = 1'b0;
      b_in = 1'b0;
      run(10);
      chk("ret_steps", nstep, 2);
      chk("ret_phase", int'(phase), 0);
      chk("ret_up", int'(up), 1);

      // Glitches: 3 cycles is filtered, 4 cycles passes both ways.
      clr();
      a_in = 1'b1;
      run(3);
      a_in = 1'b0;
      run(12);
      chk("gl3_steps", nstep, 0);
      chk("gl3_phase", int'(phase), 0);
      clr();
      a_in = 1'b1;
      run(4);
      a_in = 1'b0;
      run(14);
      chk("gl4_steps", nstep, 2);
      chk("gl4_up0", up_log[0], 1);
      chk("gl4_up1", up_log[1], 0);
      chk("gl4_phase", int'(phase), 0);
      chk("gl4_errs", nerr, 0);

      // Reset two edges into a pending change.
      clr();
      a_in = 1'b1;
      run(2);
      rst = 1'b1;
      run(1);
      chk_reset_vals("midrst");
      rst = 1'b0;
      clr();
      run(20);
      chk("midrst_steps", nstep, 0);
      chk("midrst_errs", nerr, 0);
      chk("midrst_valid", int'(valid), 1);
      chk("midrst_phase", int'(phase), 2);
      chk("midrst_errcnt", int'(err_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Front-end for the up/down counter. Converts two asynchronous quadrature inputs (A, B) into a one-cycle step pulse and a direction level.
- step gates the counter's count enable; up drives its up input.
- Inputs pass through a synchroniser and a stability filter. Illegal double-edge transitions are flagged and counted.

Parameters:
FILT_LEN, 4, consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates (legal range 1..255)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
a_in  input  1  quadrature channel A, asynchronous
b_in  input  1  quadrature channel B, asynchronous
step  output  1  one-cycle pulse per legal quadrature transition
up  output  1  direction of last legal transition, 1 = forward, held between steps
err  output  1  one-cycle pulse on an illegal transition
err_cnt  output  ERR_W  saturating count of illegal transitions
phase  output  2  filtered state {A,B}
valid  output  1  high once the decoder is in RUN

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: step=0, up=0, err=0, err_cnt=0, phase=2'b00, valid=0.
  - Synchroniser flops, filter counters and the prev-state register clear to 0.
  - FSM goes to INIT.
  - rst asserted mid-operation behaves identically: a pending step or err is not emitted.
- Synchroniser: two flops per channel (s1, s2). The filter sees s2 only.
- Per-channel filter, RUN state only:
  - If s2 equals the filtered bit, the counter clears.
  - Otherwise the counter increments.
  - On an edge where s2 still differs and the counter equals FILT_LEN-1, the filtered bit takes s2 and the counter clears.
  - A glitch lasting fewer than FILT_LEN cycles at s2 never propagates.
- FSM:
  - INIT:
    - A single stability counter increments while {s2A,s2B} is unchanged from the previous cycle, and clears on any change.
    - When it reaches FILT_LEN, phase and prev load {s2A,s2B} and the FSM goes to RUN.
    - step and err stay 0 throughout INIT.
  - RUN: decode every cycle; leave only on rst.
- Decode (registered, one cycle after phase changes), comparing prev with phase:
  - Forward sequence is 00->10->11->01->00. Any single-step forward move gives step=1, up=1.
  - Reverse sequence is 00->01->11->10->00. Any single-step reverse move gives step=1, up=0.
  - A 2-bit change (00<->11, 10<->01):
    - err=1 and step=0; up is unchanged.
    - err_cnt increments, holding at all-ones once saturated.
  - No change: step=0, err=0.
  - prev loads phase every cycle.
  - Both filters updating on the same edge is a 2-bit change and counts as an error.
- Latency: an input change sampled into s1 at edge E0 reaches phase after edge E(FILT_LEN+1). step or err is high for the single cycle after edge E(FILT_LEN+2). With FILT_LEN=4, step is visible after the 7th edge counting E0.
- Throughput: back-to-back legal transitions are accepted as long as each level holds at least FILT_LEN cycles. Each produces exactly one step.
- Wrap-around: the 01->00 and 00->01 transitions across the cycle boundary are legal single steps.
- Constraints:
  - valid=1 exactly in RUN.
  - step and err are never both 1.
  - Outputs are fully registered.

Test Plan:
- Reset release with a_in=1, b_in=1 held, FILT_LEN=4:
  - valid rises after 2 sync cycles plus 4 stable cycles, with phase=11.
  - step=0 and err=0 throughout; err_cnt=0.
- Forward drive 00->10->11->01->00, each level held 10 cycles:
  - Exactly 4 single-cycle step pulses with up=1.
  - First pulse FILT_LEN+3 edges after a_in rises; phase tracks the sequence.
- Reverse drive 00->01->11->10->00:
  - 4 step pulses, up=0 after the first; no err.
- Glitch, FILT_LEN=4: pulse a_in high for 3 cycles, then high for 4 cycles:
  - 3-cycle glitch gives no phase change and no step.
  - 4-cycle pulse gives one step (up=1) then a second step (up=0) on its return.
- Illegal transitions, ERR_W=2: from phase=00, toggle a_in and b_in together, 5 times with 10-cycle holds:
  - 5 err pulses, 0 step pulses, err_cnt sequence 1,2,3,3,3, up unchanged.
- Reset mid-operation: assert rst for 1 cycle 2 edges after a_in changes in RUN:
  - All outputs are at reset values the cycle after; no step emitted for the aborted change.
  - Decoder re-enters RUN via INIT.
